input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Conditions one asynchronous or noisy external control bit before it enters the common-module gate logic (nand2 and similar combinational cells).
- Synchronises the bit into the clk domain, then debounces it with a consecutive-cycle counter.
- Outputs a clean level, single-cycle rise/fall strobes and a saturating glitch counter.
- Sits directly upstream of the combinational common gates; `level` drives their inputs.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops; legal 2..4.
- DEBOUNCE_CYCLES, 4: consecutive synced cycles of disagreement required before `level` flips; legal 1..255.
- RESET_VAL, 1'b0: reset value of the synchroniser flops and of `level`.
- GLITCH_W, 8: width of `glitch_count`.

Ports:
- clk  input  1  sole clock; all flops on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion assumed synchronised externally.
- din  input  1  raw asynchronous input bit.
- en  input  1  debounce enable; synchroniser runs regardless.
- glitch_clr  input  1  synchronous clear of `glitch_count`.
- level  output  1  debounced, registered level.
- rise  output  1  one-cycle strobe on a 0->1 transition of `level`.
- fall  output  1  one-cycle strobe on a 1->0 transition of `level`.
- glitch_count  output  GLITCH_W  saturating count of aborted transitions.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync flops = RESET_VAL, level = RESET_VAL.
  - rise = fall = 0, glitch_count = 0.
  - FSM = STABLE, cnt = 0.
- Synchroniser: a shift chain of SYNC_STAGES flops; `sq` is the last stage. No logic between stages.
- FSM states are STABLE and VERIFY. The debounce counter `cnt` has width clog2(DEBOUNCE_CYCLES+1).
- STABLE:
  - If en=1 and sq != level: go to VERIFY with cnt = 1.
  - If DEBOUNCE_CYCLES = 1: flip `level` on that same edge and stay in STABLE.
- VERIFY:
  - sq != level and cnt < DEBOUNCE_CYCLES-1: cnt++.
  - sq != level and cnt == DEBOUNCE_CYCLES-1: on this edge level <= sq, cnt <= 0, go to STABLE.
  - sq == level (abort): cnt <= 0, go to STABLE, glitch_count++ saturating at all-ones.
- Latency: din changes once and holds. Counting the first capturing edge as edge 1, `level` changes on edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6 for defaults).
- rise/fall:
  - Registered and asserted on the same edge `level` changes, for exactly one cycle.
  - Never both high. Never asserted out of reset.
- en=0:
  - FSM forced to STABLE, cnt <= 0 on the next edge, level holds.
  - No glitch increment for an in-progress VERIFY abandoned by en.
  - Re-asserting en restarts counting from 0.
- glitch_clr=1: glitch_count <= 0. If an abort occurs in the same cycle, clear wins (result 0).
- Saturation: at 2^GLITCH_W-1 further aborts hold the value.
- Reset mid-VERIFY: everything returns to reset values immediately. No strobe is generated, even if `level` changes value due to RESET_VAL.
- din toggling every cycle:
  - `level` never changes.
  - glitch_count increments once per abort, i.e. on each VERIFY->STABLE return without a flip.

Decomposition:
- Package `common_pkg`:
  - state enum (STABLE=1'b0, VERIFY=1'b1).
  - localparam helper for counter width (clog2).
  - GLITCH_W default constant.
- Sub-module `sync_chain` (parameters STAGES, RESET_VAL; ports clk, rst_n, d, q):
  - Reusable elsewhere in common_module.
  - Instantiated once here.

Test Plan:
- Reset, defaults: hold rst_n=0 with din=1 -> level=0, rise=0, glitch_count=0; release, keep din=1 -> level=1 and rise=1 for one cycle on the 6th edge after release.
- Clean fall, defaults, level=1: din 1->0 and held -> fall=1 exactly one cycle, level=0 on edge 6, no glitch increment.
- Glitch: din=1 for 2 cycles then back to 0 (level=0) -> level stays 0, glitch_count=1; repeat 300 times -> glitch_count saturates at 255.
- Clear collision: assert glitch_clr in the same cycle an abort occurs with glitch_count=5 -> glitch_count=0 next cycle.
- Enable: en=0 while din held 1 for 20 cycles -> level stays 0; raise en -> level=1 on the 4th edge after en rises, with sq already 1.
- Reset mid-VERIFY: drop rst_n after 3 VERIFY cycles with din=1 -> level=0, cnt=0, FSM=STABLE immediately, no rise pulse.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types and constants for the common_module gate-conditioning blocks.
package common_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    VERIFY = 1'b1
  } dbc_state_e;

  localparam int GLITCH_W_DEF = 8;

  // Width needed to hold a counter that reaches n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain shift-register synchroniser; q is the last stage, no logic between stages.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {STAGES{RESET_VAL}};
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces one external control bit; emits level, edge strobes and a glitch count.
module input_conditioner
  import common_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0,
  parameter int   GLITCH_W        = GLITCH_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                en,
  input  logic                glitch_clr,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int                CNT_W      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic                sq;
  dbc_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                level_nxt, rise_nxt, fall_nxt;
  logic [GLITCH_W-1:0] glitch_nxt;
  logic                flip, abort;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (sq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= STABLE;
      cnt          <= '0;
      level        <= RESET_VAL;
      rise         <= 1'b0;
      fall         <= 1'b0;
      glitch_count <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      level        <= level_nxt;
      rise         <= rise_nxt;
      fall         <= fall_nxt;
      glitch_count <= glitch_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    flip       = 1'b0;
    abort      = 1'b0;
    level_nxt  = level;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    glitch_nxt = glitch_count;

    // Dropping en abandons any verification silently; it is not a glitch.
    if (!en) begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        STABLE: begin
          if (sq != level) begin
            if (DEBOUNCE_CYCLES == 1) begin
              flip = 1'b1;
            end else begin
              state_nxt = VERIFY;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        VERIFY: begin
          if (sq == level) begin
            abort     = 1'b1;
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            flip      = 1'b1;
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    if (flip) begin
      level_nxt = sq;
      rise_nxt  = sq;
      fall_nxt  = ~sq;
    end

    // Clear takes priority over a coincident abort.
    if (glitch_clr)
      glitch_nxt = '0;
    else if (abort && (glitch_count != GLITCH_MAX))
      glitch_nxt = glitch_count + 1'b1;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with default parameters.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       en;
  logic       glitch_clr;
  logic       level;
  logic       rise;
  logic       fall;
  logic [7:0] glitch_count;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic       din;
    logic       en;
    logic       clr;
    logic       lvl;
    logic       rs;
    logic       fl;
    logic [7:0] gc;
  } vec_t;

  vec_t tbl[$];

  input_conditioner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .en           (en),
    .glitch_clr   (glitch_clr),
    .level        (level),
    .rise         (rise),
    .fall         (fall),
    .glitch_count (glitch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic d, input logic e, input logic c, input logic l,
                     input logic r, input logic f, input logic [7:0] g);
    vec_t v;
    v.din = d; v.en = e; v.clr = c; v.lvl = l; v.rs = r; v.fl = f; v.gc = g;
    tbl.push_back(v);
  endtask

  // din high for two cycles, then low; the abort lands on the fifth edge.
  task automatic glitch(input logic clr_at_abort);
    din = 1'b1; tick(); tick();
    din = 1'b0; tick(); tick();
    glitch_clr = clr_at_abort; tick();
    glitch_clr = 1'b0; tick();
  endtask

  initial begin
    // Release -> rise at edge 6, clean fall, one glitch, clear, toggling din.
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0, 0, 0, 3);

    rst_n = 1'b0; din = 1'b1; en = 1'b1; glitch_clr = 1'b0;
    tick(); tick(); tick();
    chk("rst_level", 32'(level), 0);
    chk("rst_rise", 32'(rise), 0);
    chk("rst_fall", 32'(fall), 0);
    chk("rst_glitch", 32'(glitch_count), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      din = tbl[i].din; en = tbl[i].en; glitch_clr = tbl[i].clr;
      tick();
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d_rise", i), 32'(rise), 32'(tbl[i].rs));
      chk($sformatf("v%0d_fall", i), 32'(fall), 32'(tbl[i].fl));
      chk($sformatf("v%0d_glitch", i), 32'(glitch_count), 32'(tbl[i].gc));
    end
    glitch_clr = 1'b0;

    // Clear colliding with an abort at count 5.
    glitch(1'b0); glitch(1'b0);
    chk("glitch_five", 32'(glitch_count), 5);
    glitch(1'b1);
    chk("clr_wins", 32'(glitch_count), 0);

    // Saturation.
    for (int i = 0; i < 300; i++) glitch(1'b0);
    chk("glitch_sat", 32'(glitch_count), 255);
    chk("sat_level", 32'(level), 0);
    glitch_clr = 1'b1; tick(); glitch_clr = 1'b0;
    chk("sat_clear", 32'(glitch_count), 0);

    // Enable held low with din high, then raised.
    en = 1'b0; din = 1'b1;
    repeat (20) tick();
    chk("en_hold_level", 32'(level), 0);
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("en_edge%0d_level", i), 32'(level), 0);
    end
    tick();
    chk("en_edge4_level", 32'(level), 1);
    chk("en_edge4_rise", 32'(rise), 1);
    tick();
    chk("en_rise_once", 32'(rise), 0);

    // en dropped mid-VERIFY: no glitch, count restarts on re-enable.
    din = 1'b0; tick(); tick(); tick();
    en = 1'b0;
    repeat (5) tick();
    chk("abandon_level", 32'(level), 1);
    chk("abandon_glitch", 32'(glitch_count), 0);
    chk("abandon_state", 32'(dut.state), 0);
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("reen_edge%0d_level", i), 32'(level), 1);
    end
    tick();
    chk("reen_level", 32'(level), 0);
    chk("reen_fall", 32'(fall), 1);
    chk("reen_rise", 32'(rise), 0);

    // Reset asserted after three VERIFY cycles.
    din = 1'b1;
    repeat (5) tick();
    chk("pre_rst_state", 32'(dut.state), 1);
    chk("pre_rst_cnt", 32'(dut.cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_level", 32'(level), 0);
    chk("midrst_rise", 32'(rise), 0);
    chk("midrst_cnt", 32'(dut.cnt), 0);
    chk("midrst_state", 32'(dut.state), 0);
    din = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post_rst%0d_rise", i), 32'(rise | fall | level), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
